// File: rtl/addsub_pipe_stage_pkg.sv
// Shared types and constants for the add/subtract pipeline front end.
package addsub_pipe_stage_pkg;

  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_ADC = 2'b10,
    OP_SBB = 2'b11
  } op_e;

  // Stage-1 request payload
  typedef struct packed {
    op_e               op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } req_t;

  // Stage-2 result payload
  typedef struct packed {
    logic [DATA_W-1:0] sum;
    logic              cout;
    logic              ovf;
    logic              zero;
    logic              neg;
  } res_t;

  // Adder carry-in: plain ops use a constant, chained ops consume the carry flag
  function automatic logic cin_for(input op_e op, input logic carry);
    logic cin;
    cin = 1'b0;
    case (op)
      OP_ADD:  cin = 1'b0;
      OP_SUB:  cin = 1'b1;
      default: cin = carry;
    endcase
    return cin;
  endfunction

endpackage

// File: rtl/addsub_pipe_stage_adder32.sv
// Adder32 datapath: S = A + B + Cin with carry out.
// Ports: a, b (operands), cin (carry in), s (sum), cout (carry out).
module addsub_pipe_stage_adder32
  import addsub_pipe_stage_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              cin,
  output logic [DATA_W-1:0] s,
  output logic              cout
);

  localparam int unsigned SUM_W = DATA_W + 1;

  logic [SUM_W-1:0] full_sum;

  assign full_sum = SUM_W'(a) + SUM_W'(b) + SUM_W'(cin);
  assign s        = full_sum[DATA_W-1:0];
  assign cout     = full_sum[DATA_W];

endmodule

// File: rtl/addsub_pipe_stage.sv
// Two-stage pipelined ADD/SUB/ADC/SBB front end around the Adder32 datapath.
// Ports: clk, rst_n (async, active-low); in_valid/in_ready/in_op/in_a/in_b
// request handshake; carry_clr clears the chaining carry flag; out_valid/
// out_ready with out_sum/out_cout/out_ovf/out_zero/out_neg result stage;
// carry_flag exposes the carry used by ADC/SBB.
module addsub_pipe_stage
  import addsub_pipe_stage_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             carry_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero,
  output logic             out_neg,
  output logic             carry_flag
);

  // The Adder32 datapath is fixed width
  if (WIDTH != DATA_W) begin : g_width_err
    $error("addsub_pipe_stage: WIDTH must be %0d", DATA_W);
  end

  logic              s1_valid_q, s1_valid_d;
  req_t              s1_req_q,   s1_req_d;
  logic              out_valid_q, out_valid_d;
  res_t              res_q,      res_d;
  logic              carry_q,    carry_d;

  logic              s1_adv;
  logic              accept;
  logic [DATA_W-1:0] add_b;
  logic              add_cin;
  logic [DATA_W-1:0] add_s;
  logic              add_cout;

  addsub_pipe_stage_adder32 u_adder32 (
    .a    (s1_req_q.a),
    .b    (add_b),
    .cin  (add_cin),
    .s    (add_s),
    .cout (add_cout)
  );

  // Handshake, adder operand steering, flags and next-state
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_req_d    = s1_req_q;
    out_valid_d = out_valid_q;
    res_d       = res_q;
    carry_d     = carry_q;

    s1_adv   = s1_valid_q && (!out_valid_q || out_ready);
    in_ready = !s1_valid_q || s1_adv;
    accept   = in_valid && in_ready;

    // op[0] selects the subtracting forms: invert B
    add_b   = s1_req_q.op[0] ? ~s1_req_q.b : s1_req_q.b;
    add_cin = cin_for(s1_req_q.op, carry_q);

    if (accept) begin
      s1_valid_d  = 1'b1;
      s1_req_d.op = op_e'(in_op);
      s1_req_d.a  = DATA_W'(in_a);
      s1_req_d.b  = DATA_W'(in_b);
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end

    if (s1_adv) begin
      out_valid_d = 1'b1;
      res_d.sum   = add_s;
      res_d.cout  = add_cout;
      res_d.ovf   = (s1_req_q.a[DATA_W-1] == add_b[DATA_W-1]) &&
                    (add_s[DATA_W-1] != s1_req_q.a[DATA_W-1]);
      res_d.zero  = (add_s == '0);
      res_d.neg   = add_s[DATA_W-1];
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    // A retiring op's carry takes priority over a concurrent clear
    if (s1_adv) begin
      carry_d = add_cout;
    end else if (carry_clr) begin
      carry_d = 1'b0;
    end
  end

  // Pipeline and carry registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_req_q    <= '0;
      out_valid_q <= 1'b0;
      res_q       <= '0;
      carry_q     <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_req_q    <= s1_req_d;
      out_valid_q <= out_valid_d;
      res_q       <= res_d;
      carry_q     <= carry_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_sum    = WIDTH'(res_q.sum);
  assign out_cout   = res_q.cout;
  assign out_ovf    = res_q.ovf;
  assign out_zero   = res_q.zero;
  assign out_neg    = res_q.neg;
  assign carry_flag = carry_q;

endmodule

// File: tb/tb_addsub_pipe_stage.sv
// Directed bench for addsub_pipe_stage: vector table plus handshake,
// backpressure, reset and carry-clear sequences.
module tb_addsub_pipe_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        carry_clr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_sum;
  logic        out_cout;
  logic        out_ovf;
  logic        out_zero;
  logic        out_neg;
  logic        carry_flag;

  int n_chk  = 0;
  int n_fail = 0;

  addsub_pipe_stage dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .carry_clr  (carry_clr),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sum    (out_sum),
    .out_cout   (out_cout),
    .out_ovf    (out_ovf),
    .out_zero   (out_zero),
    .out_neg    (out_neg),
    .carry_flag (carry_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
    logic        neg;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present one request from a negedge; returns at the accepting posedge
  task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic done;
    done = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    for (int i = 0; i < 50 && !done; i++) begin
      #1;
      if (in_ready) begin
        @(posedge clk);
        done = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    if (!done) begin
      n_chk++;
      n_fail++;
      $display("FAIL send_timeout: got no accept expected accept");
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  vec_t        vecs [10];
  logic [31:0] bp_a   [4];
  logic [31:0] bp_exp [4];

  initial begin
    int          idx;
    int          rx;
    int          n_acc_stall;
    logic        have_hold;
    logic [31:0] hold_val;
    logic        acc;

    // op, a, b, sum, cout, ovf, zero, neg  (run in order; carry chains through)
    vecs[0] = '{2'b00, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{2'b01, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{2'b11, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{2'b00, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{2'b10, 32'h0000_0001, 32'h0000_0002, 32'h0000_0004, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{2'b00, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{2'b01, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{2'b10, 32'h0000_0000, 32'h0000_0000, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8] = '{2'b11, 32'h0000_000A, 32'h0000_0003, 32'h0000_0006, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[9] = '{2'b11, 32'h0000_000A, 32'h0000_0003, 32'h0000_0007, 1'b1, 1'b0, 1'b0, 1'b0};

    bp_a[0] = 32'd1; bp_exp[0] = 32'd2;
    bp_a[1] = 32'd2; bp_exp[1] = 32'd4;
    bp_a[2] = 32'd3; bp_exp[2] = 32'd6;
    bp_a[3] = 32'd4; bp_exp[3] = 32'd8;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_op     = 2'b00;
    in_a      = '0;
    in_b      = '0;
    carry_clr = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_carry", 32'(carry_flag), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_sum", out_sum, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table: one op at a time, consumer always ready
    for (int v = 0; v < 10; v++) begin
      send(vecs[v].op, vecs[v].a, vecs[v].b);
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_out_valid", v), 32'(out_valid), 32'd1);
      chk($sformatf("v%0d_sum", v), out_sum, vecs[v].sum);
      chk($sformatf("v%0d_cout", v), 32'(out_cout), 32'(vecs[v].cout));
      chk($sformatf("v%0d_ovf", v), 32'(out_ovf), 32'(vecs[v].ovf));
      chk($sformatf("v%0d_zero", v), 32'(out_zero), 32'(vecs[v].zero));
      chk($sformatf("v%0d_neg", v), 32'(out_neg), 32'(vecs[v].neg));
      chk($sformatf("v%0d_carry", v), 32'(carry_flag), 32'(vecs[v].cout));
    end
    @(posedge clk);
    #1;
    chk("idle_out_valid", 32'(out_valid), 32'd0);

    // Backpressure: four ADDs, consumer stalled for the first five cycles
    idx = 0;
    rx = 0;
    n_acc_stall = 0;
    have_hold = 1'b0;
    hold_val = '0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      out_ready = (cyc >= 5);
      in_valid  = (idx < 4);
      in_op     = 2'b00;
      in_a      = (idx < 4) ? bp_a[idx] : 32'd0;
      in_b      = (idx < 4) ? bp_a[idx] : 32'd0;
      #1;
      acc = in_valid && in_ready;
      if (cyc == 4) chk("bp_in_ready_stalled", 32'(in_ready), 32'd0);
      if (out_valid && !out_ready) begin
        if (have_hold) chk("bp_hold_stable", out_sum, hold_val);
        have_hold = 1'b1;
        hold_val  = out_sum;
      end
      if (out_valid && out_ready) begin
        if (rx < 4) chk($sformatf("bp_out%0d", rx), out_sum, bp_exp[rx]);
        else chk("bp_extra_output", 32'd1, 32'd0);
        rx++;
        have_hold = 1'b0;
      end
      if (acc && !out_ready) n_acc_stall++;
      if (acc) idx++;
      if (rx >= 4 && idx >= 4) break;
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_stall_accepts", 32'(n_acc_stall), 32'd2);
    chk("bp_received", 32'(rx), 32'd4);
    @(posedge clk);
    #1;
    chk("bp_drained", 32'(out_valid), 32'd0);

    // Reset with both stages occupied
    out_ready = 1'b0;
    send(2'b00, 32'hFFFF_FFFF, 32'h0000_0001);
    send(2'b00, 32'h0000_0001, 32'h0000_0001);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("full_out_valid", 32'(out_valid), 32'd1);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_carry", 32'(carry_flag), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_carry", 32'(carry_flag), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;

    send(2'b10, 32'h0000_0001, 32'h0000_0001);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_adc_valid", 32'(out_valid), 32'd1);
    chk("post_rst_adc_sum", out_sum, 32'h0000_0002);

    // Clear concurrent with a retiring carry-producing op: the op's carry wins
    send(2'b00, 32'hFFFF_FFFF, 32'h0000_0001);
    @(negedge clk);
    in_valid  = 1'b0;
    carry_clr = 1'b1;
    @(posedge clk);
    #1;
    chk("clr_vs_adv_carry", 32'(carry_flag), 32'd1);
    chk("clr_vs_adv_sum", out_sum, 32'h0000_0000);
    @(posedge clk);
    #1;
    chk("clr_idle_carry", 32'(carry_flag), 32'd0);
    @(negedge clk);
    carry_clr = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
